idex_hazard_stage: RTL and testbench

//  ID/EX pipeline register plus load-use hazard control for the 5-stage MIPS pipeline. Captures decoded
//  ID-stage fields and drives the IDEX_Rs/IDEX_Rt/RegWrite/MemRead fields consumed by the EX-stage

---
 rtl/mips_pipe_pkg.sv | 21 ++
 rtl/load_use_detect.sv | 24 ++
 rtl/idex_hazard_stage.sv | 187 ++++++++++++++++++
 tb/tb_idex_hazard_stage.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pipe_pkg.sv
// Shared types and constants for the 5-stage MIPS pipeline control blocks.
package mips_pipe_pkg;

  localparam int unsigned ALUOP_W  = 4;
  localparam logic [4:0]  REG_ZERO = 5'd0;

  typedef enum logic [0:0] {
    HZ_RUN,
    HZ_STALL
  } hz_state_t;

  typedef struct packed {
    logic               regwrite;
    logic               memread;
    logic               memwrite;
    logic               memtoreg;
    logic               alusrc;
    logic [ALUOP_W-1:0] aluop;
  } idex_ctrl_t;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard equation: the instruction in ID reads the register a load in EX will write.
module load_use_detect
  import mips_pipe_pkg::*;
(
  input  logic       idex_valid_i,
  input  logic       idex_memread_i,
  input  logic [4:0] idex_wreg_i,
  input  logic       id_valid_i,
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  logic       id_uses_rt_i,
  output logic       hazard_o
);

  logic rs_match, rt_match;

  always_comb begin
    rs_match = (id_rs_i == idex_wreg_i);
    rt_match = id_uses_rt_i && (id_rt_i == idex_wreg_i);
    hazard_o = idex_valid_i && idex_memread_i && (idex_wreg_i != REG_ZERO) && id_valid_i &&
               (rs_match || rt_match);
  end

endmodule

// File: rtl/idex_hazard_stage.sv
// ID/EX pipeline register with load-use stall FSM, branch squash and saturating stall counter.
module idex_hazard_stage
  import mips_pipe_pkg::*;
#(
  parameter int unsigned LOAD_USE_BUBBLES = 1,
  parameter int unsigned DATA_W           = 32,
  parameter int unsigned STALLCNT_W       = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  id_valid_i,
  input  logic [4:0]            id_rs_i,
  input  logic [4:0]            id_rt_i,
  input  logic [4:0]            id_rd_i,
  input  logic                  id_uses_rt_i,
  input  logic                  id_regdst_i,
  input  logic                  id_regwrite_i,
  input  logic                  id_memread_i,
  input  logic                  id_memwrite_i,
  input  logic                  id_memtoreg_i,
  input  logic                  id_alusrc_i,
  input  logic [ALUOP_W-1:0]    id_aluop_i,
  input  logic [DATA_W-1:0]     id_rs_data_i,
  input  logic [DATA_W-1:0]     id_rt_data_i,
  input  logic [DATA_W-1:0]     id_imm_i,
  input  logic                  ex_branch_flush_i,
  output logic                  pc_write_en_o,
  output logic                  ifid_write_en_o,
  output logic                  idex_valid_o,
  output logic [4:0]            idex_rs_o,
  output logic [4:0]            idex_rt_o,
  output logic [4:0]            idex_wreg_o,
  output logic                  idex_regwrite_o,
  output logic                  idex_memread_o,
  output logic                  idex_memwrite_o,
  output logic                  idex_memtoreg_o,
  output logic                  idex_alusrc_o,
  output logic [ALUOP_W-1:0]    idex_aluop_o,
  output logic [DATA_W-1:0]     idex_rs_data_o,
  output logic [DATA_W-1:0]     idex_rt_data_o,
  output logic [DATA_W-1:0]     idex_imm_o,
  output logic [STALLCNT_W-1:0] stall_cycles_o
);

  // Bubbles remaining after the first one, loaded on hazard detection.
  localparam logic [1:0] CntInit = 2'(LOAD_USE_BUBBLES - 1);

  hz_state_t              state_q, state_d;
  logic [1:0]             cnt_q, cnt_d;
  logic [STALLCNT_W-1:0]  stall_q, stall_d;

  idex_ctrl_t             ctrl_q, ctrl_d;
  logic                   valid_q, valid_d;
  logic [4:0]             rs_q, rs_d, rt_q, rt_d, wreg_q, wreg_d;
  logic [DATA_W-1:0]      rs_data_q, rs_data_d, rt_data_q, rt_data_d, imm_q, imm_d;

  logic hazard;
  logic load_bubble;
  logic count_bubble;
  logic hold_front;

  load_use_detect u_load_use_detect (
    .idex_valid_i   (valid_q),
    .idex_memread_i (ctrl_q.memread),
    .idex_wreg_i    (wreg_q),
    .id_valid_i     (id_valid_i),
    .id_rs_i        (id_rs_i),
    .id_rt_i        (id_rt_i),
    .id_uses_rt_i   (id_uses_rt_i),
    .hazard_o       (hazard)
  );

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= HZ_RUN;
      cnt_q   <= 2'd0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

  // Next-state logic; flush overrides both hazard and STALL
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    load_bubble  = 1'b1;
    count_bubble = 1'b0;
    if (ex_branch_flush_i) begin
      state_d = HZ_RUN;
      cnt_d   = 2'd0;
    end else begin
      unique case (state_q)
        HZ_RUN: begin
          if (hazard) begin
            count_bubble = 1'b1;
            cnt_d        = CntInit;
            state_d      = (CntInit != 2'd0) ? HZ_STALL : HZ_RUN;
          end else begin
            load_bubble = !id_valid_i;
          end
        end
        HZ_STALL: begin
          count_bubble = 1'b1;
          cnt_d        = cnt_q - 2'd1;
          if (cnt_q == 2'd1) state_d = HZ_RUN;
        end
      endcase
    end
    stall_d = (count_bubble && (stall_q != '1)) ? stall_q + STALLCNT_W'(1) : stall_q;
  end

  // Outputs
  always_comb begin
    hold_front      = !ex_branch_flush_i && ((state_q == HZ_STALL) ||
                                             ((state_q == HZ_RUN) && hazard));
    pc_write_en_o   = !hold_front;
    ifid_write_en_o = !hold_front;
  end

  always_comb begin
    ctrl_d    = '0;
    valid_d   = 1'b0;
    rs_d      = '0;
    rt_d      = '0;
    wreg_d    = '0;
    rs_data_d = '0;
    rt_data_d = '0;
    imm_d     = '0;
    if (!load_bubble) begin
      valid_d         = 1'b1;
      ctrl_d.regwrite = id_regwrite_i;
      ctrl_d.memread  = id_memread_i;
      ctrl_d.memwrite = id_memwrite_i;
      ctrl_d.memtoreg = id_memtoreg_i;
      ctrl_d.alusrc   = id_alusrc_i;
      ctrl_d.aluop    = id_aluop_i;
      rs_d            = id_rs_i;
      rt_d            = id_rt_i;
      wreg_d          = id_regdst_i ? id_rd_i : id_rt_i;
      rs_data_d       = id_rs_data_i;
      rt_data_d       = id_rt_data_i;
      imm_d           = id_imm_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ctrl_q    <= '0;
      valid_q   <= 1'b0;
      rs_q      <= '0;
      rt_q      <= '0;
      wreg_q    <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      valid_q   <= valid_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      wreg_q    <= wreg_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
    end
  end

  assign idex_valid_o    = valid_q;
  assign idex_rs_o       = rs_q;
  assign idex_rt_o       = rt_q;
  assign idex_wreg_o     = wreg_q;
  assign idex_regwrite_o = ctrl_q.regwrite;
  assign idex_memread_o  = ctrl_q.memread;
  assign idex_memwrite_o = ctrl_q.memwrite;
  assign idex_memtoreg_o = ctrl_q.memtoreg;
  assign idex_alusrc_o   = ctrl_q.alusrc;
  assign idex_aluop_o    = ctrl_q.aluop;
  assign idex_rs_data_o  = rs_data_q;
  assign idex_rt_data_o  = rt_data_q;
  assign idex_imm_o      = imm_q;
  assign stall_cycles_o  = stall_q;

endmodule

// File: tb/tb_idex_hazard_stage.sv
// Scoreboard bench: driver queues per-cycle expectations, a negedge monitor pops and compares.
module tb_idex_hazard_stage;

  typedef struct packed {
    logic        rst_n;
    logic        flush;
    logic        valid;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        uses_rt;
    logic        regdst;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        memtoreg;
    logic        alusrc;
    logic [3:0]  aluop;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
  } stim_t;

  typedef struct {
    bit          sel;
    string       name;
    logic        pcwe;
    logic        ifidwe;
    logic        vld;
    logic [4:0]  rs;
    logic [4:0]  wreg;
    logic        mr;
    logic [31:0] data;
    logic [15:0] stall;
  } exp_t;

  logic  clk;
  stim_t in1, in3;
  exp_t  q[$];
  int    checks = 0;
  int    errors = 0;

  // DUT 1: default parameters
  logic        o1_pcwe, o1_ifidwe, o1_valid, o1_regwrite, o1_memread, o1_memwrite;
  logic        o1_memtoreg, o1_alusrc;
  logic [4:0]  o1_rs, o1_rt, o1_wreg;
  logic [3:0]  o1_aluop;
  logic [31:0] o1_rs_data, o1_rt_data, o1_imm;
  logic [15:0] o1_stall;

  // DUT 3: three bubbles per hazard, 2-bit stall counter to reach saturation quickly
  logic        o3_pcwe, o3_ifidwe, o3_valid, o3_regwrite, o3_memread, o3_memwrite;
  logic        o3_memtoreg, o3_alusrc;
  logic [4:0]  o3_rs, o3_rt, o3_wreg;
  logic [3:0]  o3_aluop;
  logic [31:0] o3_rs_data, o3_rt_data, o3_imm;
  logic [1:0]  o3_stall;

  idex_hazard_stage dut1 (
    .clk_i(clk), .rst_ni(in1.rst_n), .id_valid_i(in1.valid), .id_rs_i(in1.rs),
    .id_rt_i(in1.rt), .id_rd_i(in1.rd), .id_uses_rt_i(in1.uses_rt), .id_regdst_i(in1.regdst),
    .id_regwrite_i(in1.regwrite), .id_memread_i(in1.memread), .id_memwrite_i(in1.memwrite),
    .id_memtoreg_i(in1.memtoreg), .id_alusrc_i(in1.alusrc), .id_aluop_i(in1.aluop),
    .id_rs_data_i(in1.rs_data), .id_rt_data_i(in1.rt_data), .id_imm_i(in1.imm),
    .ex_branch_flush_i(in1.flush), .pc_write_en_o(o1_pcwe), .ifid_write_en_o(o1_ifidwe),
    .idex_valid_o(o1_valid), .idex_rs_o(o1_rs), .idex_rt_o(o1_rt), .idex_wreg_o(o1_wreg),
    .idex_regwrite_o(o1_regwrite), .idex_memread_o(o1_memread), .idex_memwrite_o(o1_memwrite),
    .idex_memtoreg_o(o1_memtoreg), .idex_alusrc_o(o1_alusrc), .idex_aluop_o(o1_aluop),
    .idex_rs_data_o(o1_rs_data), .idex_rt_data_o(o1_rt_data), .idex_imm_o(o1_imm),
    .stall_cycles_o(o1_stall)
  );

  idex_hazard_stage #(.LOAD_USE_BUBBLES(3), .DATA_W(32), .STALLCNT_W(2)) dut3 (
    .clk_i(clk), .rst_ni(in3.rst_n), .id_valid_i(in3.valid), .id_rs_i(in3.rs),
    .id_rt_i(in3.rt), .id_rd_i(in3.rd), .id_uses_rt_i(in3.uses_rt), .id_regdst_i(in3.regdst),
    .id_regwrite_i(in3.regwrite), .id_memread_i(in3.memread), .id_memwrite_i(in3.memwrite),
    .id_memtoreg_i(in3.memtoreg), .id_alusrc_i(in3.alusrc), .id_aluop_i(in3.aluop),
    .id_rs_data_i(in3.rs_data), .id_rt_data_i(in3.rt_data), .id_imm_i(in3.imm),
    .ex_branch_flush_i(in3.flush), .pc_write_en_o(o3_pcwe), .ifid_write_en_o(o3_ifidwe),
    .idex_valid_o(o3_valid), .idex_rs_o(o3_rs), .idex_rt_o(o3_rt), .idex_wreg_o(o3_wreg),
    .idex_regwrite_o(o3_regwrite), .idex_memread_o(o3_memread), .idex_memwrite_o(o3_memwrite),
    .idex_memtoreg_o(o3_memtoreg), .idex_alusrc_o(o3_alusrc), .idex_aluop_o(o3_aluop),
    .idex_rs_data_o(o3_rs_data), .idex_rt_data_o(o3_rt_data), .idex_imm_o(o3_imm),
    .stall_cycles_o(o3_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t f_nop();
    stim_t s;
    s = '0;
    s.rst_n = 1'b1;
    return s;
  endfunction

  function automatic stim_t f_lw(input logic [4:0] rs, input logic [4:0] rt);
    stim_t s;
    s = f_nop();
    s.valid = 1'b1; s.rs = rs; s.rt = rt;
    s.regwrite = 1'b1; s.memread = 1'b1; s.memtoreg = 1'b1; s.alusrc = 1'b1;
    s.rs_data = 32'h1000 + 32'(rs); s.rt_data = 32'h2000 + 32'(rt); s.imm = 32'd4;
    return s;
  endfunction

  function automatic stim_t f_add(input logic [4:0] rd, input logic [4:0] rs,
                                  input logic [4:0] rt);
    stim_t s;
    s = f_nop();
    s.valid = 1'b1; s.rs = rs; s.rt = rt; s.rd = rd; s.uses_rt = 1'b1; s.regdst = 1'b1;
    s.regwrite = 1'b1; s.aluop = 4'd2;
    s.rs_data = 32'h1000 + 32'(rs); s.rt_data = 32'h2000 + 32'(rt);
    return s;
  endfunction

  function automatic stim_t f_sw(input logic [4:0] rs, input logic [4:0] rt);
    stim_t s;
    s = f_nop();
    s.valid = 1'b1; s.rs = rs; s.rt = rt; s.memwrite = 1'b1; s.alusrc = 1'b1;
    s.rs_data = 32'h1000 + 32'(rs); s.rt_data = 32'h2000 + 32'(rt); s.imm = 32'd8;
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit sel, input stim_t s);
    if (sel) in3 = s;
    else     in1 = s;
  endtask

  task automatic expect_o(input bit sel, input string name, input logic pcwe, input logic vld,
                          input logic [4:0] rs, input logic [4:0] wreg, input logic mr,
                          input logic [31:0] data, input logic [15:0] stall);
    exp_t e;
    e.sel = sel; e.name = name; e.pcwe = pcwe; e.ifidwe = pcwe; e.vld = vld; e.rs = rs;
    e.wreg = wreg; e.mr = mr; e.data = data; e.stall = stall;
    q.push_back(e);
  endtask

  task automatic expect_bubble(input bit sel, input string name, input logic pcwe,
                               input logic [15:0] stall);
    expect_o(sel, name, pcwe, 1'b0, 5'd0, 5'd0, 1'b0, 32'd0, stall);
  endtask

  // Monitor: compares one queued expectation per cycle against the selected DUT
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e, a;
      e = q.pop_front();
      a = e;
      if (e.sel) begin
        a.pcwe = o3_pcwe; a.ifidwe = o3_ifidwe; a.vld = o3_valid; a.rs = o3_rs;
        a.wreg = o3_wreg; a.mr = o3_memread; a.data = o3_rs_data; a.stall = {14'd0, o3_stall};
      end else begin
        a.pcwe = o1_pcwe; a.ifidwe = o1_ifidwe; a.vld = o1_valid; a.rs = o1_rs;
        a.wreg = o1_wreg; a.mr = o1_memread; a.data = o1_rs_data; a.stall = o1_stall;
      end
      checks++;
      if (a.pcwe !== e.pcwe || a.ifidwe !== e.ifidwe || a.vld !== e.vld || a.rs !== e.rs ||
          a.wreg !== e.wreg || a.mr !== e.mr || a.data !== e.data || a.stall !== e.stall) begin
        errors++;
        $display("FAIL %s: got pcwe=%0b ifidwe=%0b vld=%0b rs=%0d wreg=%0d mr=%0b data=%h stall=%h; want pcwe=%0b ifidwe=%0b vld=%0b rs=%0d wreg=%0d mr=%0b data=%h stall=%h",
                 e.name, a.pcwe, a.ifidwe, a.vld, a.rs, a.wreg, a.mr, a.data, a.stall,
                 e.pcwe, e.ifidwe, e.vld, e.rs, e.wreg, e.mr, e.data, e.stall);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1);
  end

  initial begin
    stim_t s;
    in1 = f_lw(5'd1, 5'd8);
    in1.rst_n = 1'b0;
    in3 = f_nop();
    in3.rst_n = 1'b0;

    // ---- DUT 1 ----
    tick();
    tick();                 expect_bubble(0, "reset", 1'b1, 16'd0);
    tick(); drive(0, f_nop()); expect_bubble(0, "reset_release", 1'b1, 16'd0);

    // lw $8 ; add $9,$8,$10
    tick(); drive(0, f_lw(5'd1, 5'd8));       expect_bubble(0, "lu_issue", 1'b1, 16'd0);
    tick(); drive(0, f_add(5'd9, 5'd8, 5'd10));
    expect_o(0, "lu_stall", 1'b0, 1'b1, 5'd1, 5'd8, 1'b1, 32'h1001, 16'd0);
    tick();                                    expect_bubble(0, "lu_bubble", 1'b1, 16'd1);
    tick(); drive(0, f_nop());
    expect_o(0, "lu_resume", 1'b1, 1'b1, 5'd8, 5'd9, 1'b0, 32'h1008, 16'd1);

    // lw $0 then add using $0
    tick(); drive(0, f_lw(5'd1, 5'd0));       expect_bubble(0, "lw0_issue", 1'b1, 16'd1);
    tick(); drive(0, f_add(5'd9, 5'd0, 5'd0));
    expect_o(0, "lw0_nostall", 1'b1, 1'b1, 5'd1, 5'd0, 1'b1, 32'h1001, 16'd1);
    tick(); drive(0, f_nop());
    expect_o(0, "lw0_pass", 1'b1, 1'b1, 5'd0, 5'd9, 1'b0, 32'h1000, 16'd1);

    // lw $8 then store with rt=8 but uses_rt=0, rs=3
    tick(); drive(0, f_lw(5'd1, 5'd8));       expect_bubble(0, "sw_issue", 1'b1, 16'd1);
    tick(); drive(0, f_sw(5'd3, 5'd8));
    expect_o(0, "sw_nostall", 1'b1, 1'b1, 5'd1, 5'd8, 1'b1, 32'h1001, 16'd1);
    tick(); drive(0, f_nop());
    expect_o(0, "sw_pass", 1'b1, 1'b1, 5'd3, 5'd8, 1'b0, 32'h1003, 16'd1);

    // hazard through rt
    tick(); drive(0, f_lw(5'd1, 5'd8));       expect_bubble(0, "rt_issue", 1'b1, 16'd1);
    tick(); drive(0, f_add(5'd9, 5'd10, 5'd8));
    expect_o(0, "rt_stall", 1'b0, 1'b1, 5'd1, 5'd8, 1'b1, 32'h1001, 16'd1);
    tick();                                    expect_bubble(0, "rt_bubble", 1'b1, 16'd2);
    tick(); drive(0, f_nop());
    expect_o(0, "rt_resume", 1'b1, 1'b1, 5'd10, 5'd9, 1'b0, 32'h100a, 16'd2);

    // hazard and flush in the same cycle
    tick(); drive(0, f_lw(5'd1, 5'd8));       expect_bubble(0, "fh_issue", 1'b1, 16'd2);
    tick(); s = f_add(5'd9, 5'd8, 5'd10); s.flush = 1'b1; drive(0, s);
    expect_o(0, "flush_haz", 1'b1, 1'b1, 5'd1, 5'd8, 1'b1, 32'h1001, 16'd2);
    tick(); drive(0, f_nop());                 expect_bubble(0, "flush_bubble", 1'b1, 16'd2);

    // ---- DUT 3 (three bubbles, 2-bit counter) ----
    tick(); drive(1, f_nop());                 expect_bubble(1, "b3_reset", 1'b1, 16'd0);
    tick(); drive(1, f_lw(5'd2, 5'd5));       expect_bubble(1, "b3_issue", 1'b1, 16'd0);
    tick(); drive(1, f_add(5'd6, 5'd5, 5'd5));
    expect_o(1, "b3_c1", 1'b0, 1'b1, 5'd2, 5'd5, 1'b1, 32'h1002, 16'd0);
    tick();                                    expect_bubble(1, "b3_c2", 1'b0, 16'd1);
    tick();                                    expect_bubble(1, "b3_c3", 1'b0, 16'd2);
    tick();                                    expect_bubble(1, "b3_done", 1'b1, 16'd3);
    tick(); drive(1, f_nop());
    expect_o(1, "b3_pass", 1'b1, 1'b1, 5'd5, 5'd6, 1'b0, 32'h1005, 16'd3);

    // second hazard: counter already all-ones
    tick(); drive(1, f_lw(5'd2, 5'd5));       expect_bubble(1, "sat_issue", 1'b1, 16'd3);
    tick(); drive(1, f_add(5'd6, 5'd5, 5'd5));
    expect_o(1, "sat_c1", 1'b0, 1'b1, 5'd2, 5'd5, 1'b1, 32'h1002, 16'd3);
    tick();                                    expect_bubble(1, "sat_c2", 1'b0, 16'd3);
    tick();                                    expect_bubble(1, "sat_c3", 1'b0, 16'd3);
    tick();                                    expect_bubble(1, "sat_done", 1'b1, 16'd3);
    tick(); drive(1, f_nop());
    expect_o(1, "sat_pass", 1'b1, 1'b1, 5'd5, 5'd6, 1'b0, 32'h1005, 16'd3);

    // flush while in STALL with cnt=2
    tick(); drive(1, f_lw(5'd2, 5'd5));       expect_bubble(1, "sf_issue", 1'b1, 16'd3);
    tick(); drive(1, f_add(5'd6, 5'd5, 5'd5));
    expect_o(1, "sf_haz", 1'b0, 1'b1, 5'd2, 5'd5, 1'b1, 32'h1002, 16'd3);
    tick(); s = f_add(5'd6, 5'd5, 5'd5); s.flush = 1'b1; drive(1, s);
    expect_bubble(1, "stall_flush", 1'b1, 16'd3);
    tick(); drive(1, f_add(5'd6, 5'd5, 5'd5)); expect_bubble(1, "stall_flush_run", 1'b1, 16'd3);
    tick(); drive(1, f_nop());
    expect_o(1, "sf_pass", 1'b1, 1'b1, 5'd5, 5'd6, 1'b0, 32'h1005, 16'd3);

    // reset while in STALL
    tick(); drive(1, f_lw(5'd2, 5'd5));       expect_bubble(1, "rs_issue", 1'b1, 16'd3);
    tick(); drive(1, f_add(5'd6, 5'd5, 5'd5));
    expect_o(1, "rs_haz", 1'b0, 1'b1, 5'd2, 5'd5, 1'b1, 32'h1002, 16'd3);
    tick(); s = f_add(5'd6, 5'd5, 5'd5); s.rst_n = 1'b0; drive(1, s);
    expect_bubble(1, "rst_in_stall", 1'b0, 16'd3);
    tick(); drive(1, f_nop());                 expect_bubble(1, "rst_to_run", 1'b1, 16'd0);
    tick();                                    expect_bubble(1, "rst_idle", 1'b1, 16'd0);

    tick();
    tick();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d unchecked expectations, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
